led_pattern_sequencer: RTL

// Drives the address/enable side of the reconfigurable LED pattern ROM (the shift/count RM, 1-cycle read latency).

---
 rtl/led_seq_pkg.sv | 15 +
 rtl/led_seq_prescaler.sv | 30 +++
 rtl/led_pattern_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared state encoding and default widths for the LED pattern sequencer
package led_seq_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_PARK
  } state_t;

endpackage

// File: rtl/led_seq_prescaler.sv
// rtl/led_seq_prescaler.sv - step-rate prescaler with clear, hold and terminal-count tick
module led_seq_prescaler #(
  parameter int PRESCALE = 50_000_000,
  parameter int PRESC_W  = 26
) (
  input  logic clk,
  input  logic en,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] cnt;

  assign tick = run && !clear && (cnt == LAST);

  // Counter wraps to zero on its own tick so back-to-back periods stay PRESCALE long.
  always_ff @(posedge clk) begin
    if (!en) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - walks an address window of the pattern RM and holds the returned LED pattern
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PRESCALE = 50_000_000,
  parameter int PRESC_W  = 26
) (
  input  logic              clk,
  input  logic              en,
  input  logic              decouple,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              dir,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rm_addr,
  output logic              rm_en,
  input  logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] leds,
  output logic              wrap_pulse
);

  state_t            state;
  logic [ADDR_W-1:0] win_lo;
  logic [ADDR_W-1:0] win_hi;
  logic [ADDR_W-1:0] next_addr;
  logic              next_wrap;
  logic              presc_run;
  logic              presc_clear;
  logic              tick;
  logic              in_window;

  assign presc_run   = (state == ST_WAIT);
  assign presc_clear = !presc_run || step_mode || decouple;

  led_seq_prescaler #(
    .PRESCALE(PRESCALE),
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .en   (en),
    .clear(presc_clear),
    .run  (presc_run),
    .tick (tick)
  );

  // An inverted window pins the address to its low bound.
  function automatic logic [ADDR_W-1:0] load_addr(input logic [ADDR_W-1:0] lo,
                                                   input logic [ADDR_W-1:0] hi,
                                                   input logic              d);
    logic [ADDR_W-1:0] a;
    a = d ? hi : lo;
    if (lo > hi) a = lo;
    return a;
  endfunction

  assign in_window = (rm_addr >= start_addr) && (rm_addr <= end_addr);

  always_comb begin
    next_addr = rm_addr;
    next_wrap = 1'b0;
    if (win_lo > win_hi) begin
      next_addr = win_lo;
      next_wrap = 1'b1;
    end else if (!dir) begin
      if (rm_addr == win_hi) begin
        next_addr = win_lo;
        next_wrap = 1'b1;
      end else begin
        next_addr = rm_addr + 1'b1;
      end
    end else begin
      if (rm_addr == win_lo) begin
        next_addr = win_hi;
        next_wrap = 1'b1;
      end else begin
        next_addr = rm_addr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!en) begin
      state      <= ST_IDLE;
      rm_addr    <= '0;
      rm_en      <= 1'b0;
      leds       <= '0;
      wrap_pulse <= 1'b0;
      win_lo     <= '0;
      win_hi     <= '0;
    end else begin
      rm_en      <= 1'b0;
      wrap_pulse <= 1'b0;
      if (decouple) begin
        state <= ST_PARK;
      end else begin
        case (state)
          ST_IDLE: begin
            win_lo  <= start_addr;
            win_hi  <= end_addr;
            rm_addr <= load_addr(start_addr, end_addr, dir);
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            if (step_mode ? step_req : tick) begin
              rm_en <= 1'b1;
              state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            state <= ST_LATCH;
          end
          ST_LATCH: begin
            leds       <= rm_data;
            rm_addr    <= next_addr;
            wrap_pulse <= next_wrap;
            state      <= ST_WAIT;
          end
          ST_PARK: begin
            win_lo <= start_addr;
            win_hi <= end_addr;
            if (!in_window) rm_addr <= load_addr(start_addr, end_addr, dir);
            state <= ST_WAIT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
